// File: rtl/alu_op_sequencer.sv
// Byte-stream front-end for the 8-bit ALU: collects A, B and opcode, registers them onto the
// ALU ports, then returns the ALU result and flags over a valid/ready handshake.
module alu_op_sequencer #(
    parameter int unsigned W   = 8,
    parameter int unsigned OPW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   alu_A,
    output logic [W-1:0]   alu_B,
    output logic [OPW-1:0] alu_OpCode,
    input  logic [W-1:0]   alu_Result,
    input  logic           alu_V,
    input  logic           alu_C,
    input  logic           alu_Z,
    input  logic           alu_N,
    output logic [W-1:0]   res_data,
    output logic [3:0]     res_flags,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic [7:0]     op_count
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        RESP
    } state_t;

    state_t state, state_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GET_A;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            GET_A: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_n = GET_B;
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) state_n = GET_OP;
            end
            GET_OP: begin
                in_ready = 1'b1;
                if (in_valid) state_n = EXEC;
            end
            EXEC: state_n = RESP;
            RESP: begin
                if (res_ready) state_n = GET_A;
            end
            default: state_n = GET_A;
        endcase
    end

    // Operands and results only move on their own beat/edge so the ALU never sees mixed inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_OpCode <= '0;
            res_data   <= '0;
            res_flags  <= '0;
            res_valid  <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                GET_A:  if (in_valid) alu_A <= in_data;
                GET_B:  if (in_valid) alu_B <= in_data;
                GET_OP: if (in_valid) alu_OpCode <= in_data[OPW-1:0];
                EXEC: begin
                    res_data  <= alu_Result;
                    res_flags <= {alu_V, alu_C, alu_Z, alu_N};
                    res_valid <= 1'b1;
                    op_count  <= op_count + 8'd1;
                end
                RESP: if (res_valid && res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU stub plus a transaction-level
// reference model of byte collection, result timing and the operation counter.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_A, alu_B;
    logic [1:0] alu_OpCode;
    logic [7:0] alu_Result;
    logic       alu_V, alu_C, alu_Z, alu_N;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic [7:0] op_count;
    logic       stub_mode;

    int errors = 0;
    int checks = 0;

    // Reference model state (transaction level).
    int         phase;
    bit         pending, rv;
    logic [7:0] ma, mb;
    logic [1:0] mop;
    logic [11:0] exp_next, last;
    logic [7:0] cnt;
    int         done;

    always #5 clk = ~clk;

    alu_op_sequencer #(.W(8), .OPW(2)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_A(alu_A), .alu_B(alu_B), .alu_OpCode(alu_OpCode),
        .alu_Result(alu_Result), .alu_V(alu_V), .alu_C(alu_C), .alu_Z(alu_Z), .alu_N(alu_N),
        .res_data(res_data), .res_flags(res_flags), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .op_count(op_count)
    );

    // ALU behaviour: add, sub, and, xor; or a fixed 0x5A / 4'b0101 stub.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op, input logic stub);
        logic [8:0] s;
        logic [7:0] r;
        logic       v, c;
        s = '0;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        if (stub) return {8'h5A, 4'b0101};
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        return {r, v, c, (r == 8'h00), r[7]};
    endfunction

    always_comb {alu_Result, alu_V, alu_C, alu_Z, alu_N} = alu_ref(alu_A, alu_B, alu_OpCode, stub_mode);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase   = 0;
        pending = 1'b0;
        rv      = 1'b0;
        ma      = '0;
        mb      = '0;
        mop     = '0;
        last    = '0;
        cnt     = '0;
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({pfx, "_alu_A"}, 32'(alu_A), 32'd0);
        chk({pfx, "_alu_B"}, 32'(alu_B), 32'd0);
        chk({pfx, "_alu_op"}, 32'(alu_OpCode), 32'd0);
        chk({pfx, "_res_data"}, 32'(res_data), 32'd0);
        chk({pfx, "_res_flags"}, 32'(res_flags), 32'd0);
        chk({pfx, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    // Called at a falling edge: check outputs against the model, drive the next cycle's inputs,
    // advance the model across the coming rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic rr);
        chk("in_ready", 32'(in_ready), 32'(!pending));
        chk("busy", 32'(busy), 32'(pending || phase != 0));
        chk("res_valid", 32'(res_valid), 32'(rv));
        chk("alu_A", 32'(alu_A), 32'(ma));
        chk("alu_B", 32'(alu_B), 32'(mb));
        chk("alu_op", 32'(alu_OpCode), 32'(mop));
        chk("res_data", 32'(res_data), 32'(last[11:4]));
        chk("res_flags", 32'(res_flags), 32'(last[3:0]));
        chk("op_count", 32'(op_count), 32'(cnt));
        in_valid  = v;
        in_data   = d;
        res_ready = rr;
        if (!pending) begin
            if (v) begin
                case (phase)
                    0: ma = d;
                    1: mb = d;
                    default: begin
                        mop      = d[1:0];
                        pending  = 1'b1;
                        exp_next = alu_ref(ma, mb, d[1:0], stub_mode);
                    end
                endcase
                phase = (phase + 1) % 3;
            end
        end else if (!rv) begin
            rv   = 1'b1;
            last = exp_next;
            cnt  = cnt + 8'd1;
        end else if (rr) begin
            rv      = 1'b0;
            pending = 1'b0;
            done++;
        end
        @(negedge clk);
    endtask

    initial begin
        int budget;
        int target;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        stub_mode = 1'b0;
        done      = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b1;

        // Basic add with in_valid held high.
        step(1'b1, 8'h05, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        chk("t1_alu_A", 32'(alu_A), 32'h05);
        chk("t1_alu_B", 32'(alu_B), 32'h03);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_data", 32'(res_data), 32'h08);
        chk("t1_res_flags", 32'(res_flags), 32'h0);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_res_valid_drop", 32'(res_valid), 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd1);

        // Stubbed ALU, opcode upper bits dropped, consumer stalls for 10 cycles.
        stub_mode = 1'b1;
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'hFE, 1'b0);
        chk("t2_opcode", 32'(alu_OpCode), 32'h2);
        repeat (11) step(1'b0, 8'h00, 1'b0);
        chk("t2_res_data", 32'(res_data), 32'h5A);
        chk("t2_res_flags", 32'(res_flags), 32'h5);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("t2_res_valid_drop", 32'(res_valid), 32'd0);
        chk("t2_in_ready_rise", 32'(in_ready), 32'd1);
        stub_mode = 1'b0;

        // in_valid toggling every cycle, random data and random res_ready.
        for (int i = 0; i < 48; i++)
            step((i % 2) == 0, 8'($urandom), $urandom_range(0, 1) != 0);
        repeat (12) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset with A and B already loaded.
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        #2 reset = 1'b0;
        #1 chk_reset_values("t4_async");
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        step(1'b1, 8'h40, 1'b1);
        step(1'b1, 8'h50, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        repeat (6) step(1'b0, 8'h00, 1'b1);
        chk("t4_op_count", 32'(op_count), 32'd1);

        // 256 randomized operations from reset: counter must wrap to zero.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        budget = 0;
        target = done + 256;
        while (done < target && budget < 8000) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
            budget++;
        end
        chk("t5_timeout", 32'(budget < 8000), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("t5_op_count_wrap", 32'(op_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
